decode_stage: RTL and testbench



---
 rtl/decode_pkg.sv | 140 ++++++++++++++
 rtl/decode_comb.sv | 164 ++++++++++++++++
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
// Holds opcodes, op-vector widths, one-hot bit indices, the decoded_t record
// and the immediate-format enum. The M-extension is enabled by the
// DECODE_STAGE_MEXT_EN macro (see decode_comb).
package decode_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_CUSTOM = 7'b0011111;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // Op-vector widths
  localparam int ALU_W  = 19;
  localparam int JMP_W  = 9;
  localparam int MEM_W  = 9;
  localparam int CSR_W  = 6;
  localparam int MACH_W = 8;
  localparam int MUL_W  = 8;

  // ALU bit indices
  localparam int ALU_ADDI  = 0;
  localparam int ALU_SLTI  = 1;
  localparam int ALU_SLTIU = 2;
  localparam int ALU_XORI  = 3;
  localparam int ALU_ORI   = 4;
  localparam int ALU_ANDI  = 5;
  localparam int ALU_SLLI  = 6;
  localparam int ALU_SRLI  = 7;
  localparam int ALU_SRAI  = 8;
  localparam int ALU_ADD   = 9;
  localparam int ALU_SUB   = 10;
  localparam int ALU_SLL   = 11;
  localparam int ALU_SLT   = 12;
  localparam int ALU_SLTU  = 13;
  localparam int ALU_XOR   = 14;
  localparam int ALU_SRL   = 15;
  localparam int ALU_SRA   = 16;
  localparam int ALU_OR    = 17;
  localparam int ALU_AND   = 18;

  // Jump / branch bit indices
  localparam int JMP_JAL   = 0;
  localparam int JMP_JALR  = 1;
  localparam int JMP_BEQ   = 2;
  localparam int JMP_BNE   = 3;
  localparam int JMP_BLT   = 4;
  localparam int JMP_BGE   = 5;
  localparam int JMP_BLTU  = 6;
  localparam int JMP_BGEU  = 7;
  localparam int JMP_AUIPC = 8;

  // Memory bit indices
  localparam int MEM_LUI = 0;
  localparam int MEM_LB  = 1;
  localparam int MEM_LH  = 2;
  localparam int MEM_LW  = 3;
  localparam int MEM_LBU = 4;
  localparam int MEM_LHU = 5;
  localparam int MEM_SB  = 6;
  localparam int MEM_SH  = 7;
  localparam int MEM_SW  = 8;

  // CSR bit indices (funct3 001/010/011/101/110/111)
  localparam int CSR_RW  = 0;
  localparam int CSR_RS  = 1;
  localparam int CSR_RC  = 2;
  localparam int CSR_RWI = 3;
  localparam int CSR_RSI = 4;
  localparam int CSR_RCI = 5;

  // Machine bit indices
  localparam int MACH_EBREAK = 0;
  localparam int MACH_ECALL  = 1;

  // M-extension bit indices (bit = funct3)
  localparam int MUL_MUL    = 0;
  localparam int MUL_MULH   = 1;
  localparam int MUL_MULHSU = 2;
  localparam int MUL_MULHU  = 3;
  localparam int MUL_DIV    = 4;
  localparam int MUL_DIVU   = 5;
  localparam int MUL_REM    = 6;
  localparam int MUL_REMU   = 7;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // Immediate is kept at 32 bits here; the stage sign-extends it to XLEN.
  typedef struct packed {
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic [ALU_W-1:0]  alu_op;
    logic [JMP_W-1:0]  jmp_op;
    logic [MEM_W-1:0]  mem_op;
    logic [CSR_W-1:0]  csr_op;
    logic [MACH_W-1:0] machine_op;
    logic              cust_op;
    logic [MUL_W-1:0]  mul_op;
    logic              illegal;
  } decoded_t;

  // Assemble the 32-bit sign-extended immediate for a given format.
  function automatic logic [31:0] build_imm(imm_fmt_e fmt, logic [31:0] instr);
    case (fmt)
      FMT_I:   build_imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   build_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   build_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
      FMT_U:   build_imm = {instr[31:12], 12'b0};
      FMT_J:   build_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
      default: build_imm = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: instruction word -> decoded_t.
// Defining DECODE_STAGE_MEXT_EN adds RV32M decode on OP/funct7=0000001;
// otherwise those encodings are illegal and mul_op stays zero.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_fmt_e   fmt;
  logic       illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Classify the instruction, set its one-hot op bit and pick the immediate format
  always_comb begin
    dec     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    dec.rd  = instr[11:7];
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];

    case (opcode)
      OPC_LUI: begin
        dec.mem_op[MEM_LUI] = 1'b1;
        fmt = FMT_U;
      end
      OPC_AUIPC: begin
        dec.jmp_op[JMP_AUIPC] = 1'b1;
        fmt = FMT_U;
      end
      OPC_JAL: begin
        dec.jmp_op[JMP_JAL] = 1'b1;
        fmt = FMT_J;
      end
      OPC_JALR: begin
        fmt = FMT_I;
        if (funct3 == 3'b000) dec.jmp_op[JMP_JALR] = 1'b1;
        else                  illegal = 1'b1;
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        case (funct3)
          3'b000:  dec.jmp_op[JMP_BEQ]  = 1'b1;
          3'b001:  dec.jmp_op[JMP_BNE]  = 1'b1;
          3'b100:  dec.jmp_op[JMP_BLT]  = 1'b1;
          3'b101:  dec.jmp_op[JMP_BGE]  = 1'b1;
          3'b110:  dec.jmp_op[JMP_BLTU] = 1'b1;
          3'b111:  dec.jmp_op[JMP_BGEU] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt = FMT_I;
        case (funct3)
          3'b000:  dec.mem_op[MEM_LB]  = 1'b1;
          3'b001:  dec.mem_op[MEM_LH]  = 1'b1;
          3'b010:  dec.mem_op[MEM_LW]  = 1'b1;
          3'b100:  dec.mem_op[MEM_LBU] = 1'b1;
          3'b101:  dec.mem_op[MEM_LHU] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S;
        case (funct3)
          3'b000:  dec.mem_op[MEM_SB] = 1'b1;
          3'b001:  dec.mem_op[MEM_SH] = 1'b1;
          3'b010:  dec.mem_op[MEM_SW] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        fmt = FMT_I;
        case (funct3)
          3'b000: dec.alu_op[ALU_ADDI]  = 1'b1;
          3'b010: dec.alu_op[ALU_SLTI]  = 1'b1;
          3'b011: dec.alu_op[ALU_SLTIU] = 1'b1;
          3'b100: dec.alu_op[ALU_XORI]  = 1'b1;
          3'b110: dec.alu_op[ALU_ORI]   = 1'b1;
          3'b111: dec.alu_op[ALU_ANDI]  = 1'b1;
          3'b001: begin
            if (funct7 == F7_BASE) dec.alu_op[ALU_SLLI] = 1'b1;
            else                   illegal = 1'b1;
          end
          default: begin
            // funct3 101: shift right, logical or arithmetic by funct7
            if (funct7 == F7_BASE)     dec.alu_op[ALU_SRLI] = 1'b1;
            else if (funct7 == F7_ALT) dec.alu_op[ALU_SRAI] = 1'b1;
            else                       illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        fmt = FMT_R;
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  dec.alu_op[ALU_ADD]  = 1'b1;
              3'b001:  dec.alu_op[ALU_SLL]  = 1'b1;
              3'b010:  dec.alu_op[ALU_SLT]  = 1'b1;
              3'b011:  dec.alu_op[ALU_SLTU] = 1'b1;
              3'b100:  dec.alu_op[ALU_XOR]  = 1'b1;
              3'b101:  dec.alu_op[ALU_SRL]  = 1'b1;
              3'b110:  dec.alu_op[ALU_OR]   = 1'b1;
              default: dec.alu_op[ALU_AND]  = 1'b1;
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000)      dec.alu_op[ALU_SUB] = 1'b1;
            else if (funct3 == 3'b101) dec.alu_op[ALU_SRA] = 1'b1;
            else                       illegal = 1'b1;
          end
`ifdef DECODE_STAGE_MEXT_EN
          F7_MEXT: dec.mul_op[MUL_MUL + int'(funct3)] = 1'b1;
`else
          F7_MEXT: illegal = 1'b1;
`endif
          default: illegal = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'b000: begin
            if (instr == INSTR_ECALL)       dec.machine_op[MACH_ECALL]  = 1'b1;
            else if (instr == INSTR_EBREAK) dec.machine_op[MACH_EBREAK] = 1'b1;
            else                            illegal = 1'b1;
          end
          3'b001: begin dec.csr_op[CSR_RW]  = 1'b1; fmt = FMT_I; end
          3'b010: begin dec.csr_op[CSR_RS]  = 1'b1; fmt = FMT_I; end
          3'b011: begin dec.csr_op[CSR_RC]  = 1'b1; fmt = FMT_I; end
          3'b101: begin dec.csr_op[CSR_RWI] = 1'b1; fmt = FMT_I; end
          3'b110: begin dec.csr_op[CSR_RSI] = 1'b1; fmt = FMT_I; end
          3'b111: begin dec.csr_op[CSR_RCI] = 1'b1; fmt = FMT_I; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_CUSTOM: dec.cust_op = 1'b1;
      default:    illegal = 1'b1;
    endcase

    // An illegal word carries no operation and no immediate
    if (illegal) begin
      dec.alu_op     = '0;
      dec.jmp_op     = '0;
      dec.mem_op     = '0;
      dec.csr_op     = '0;
      dec.machine_op = '0;
      dec.cust_op    = 1'b0;
      dec.mul_op     = '0;
      fmt            = FMT_NONE;
    end
    dec.illegal = illegal;
    dec.imm     = build_imm(fmt, instr);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32I decode stage between fetch and execute.
// Decodes on accept into a 2-entry FIFO so fetch and execute stall
// independently; counts consumed entries. Optional RV32M decode is enabled
// with the DECODE_STAGE_MEXT_EN macro.
module decode_stage
  import decode_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter int          CNT_W         = 32,
  parameter logic [31:0] ILLEGAL_CAUSE = 32'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic [ALU_W-1:0]  out_alu_op,
  output logic [JMP_W-1:0]  out_jmp_op,
  output logic [MEM_W-1:0]  out_mem_op,
  output logic [CSR_W-1:0]  out_csr_op,
  output logic [MACH_W-1:0] out_machine_op,
  output logic              out_cust_op,
  output logic [MUL_W-1:0]  out_mul_op,
  output logic              out_illegal,
  output logic [31:0]       out_cause,
  output logic [CNT_W-1:0]  decoded_count
);

  // ---- stage p0: combinational decode of the incoming word ----
  decoded_t dec_p0;

  decode_comb u_decode_comb (
    .instr (in_instr),
    .dec   (dec_p0)
  );

  // ---- stage p1: 2-entry FIFO holding decoded entries ----
  decoded_t          dec_p1 [2];
  logic [XLEN-1:0]   pc_p1  [2];
  logic [1:0]        occ_p1;
  logic              wr_ptr_p1;
  logic              rd_ptr_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  count_p1;
  logic              push;
  logic              pop;
  decoded_t          head;
  logic signed [31:0] imm_s;

  assign in_ready      = (occ_p1 != 2'd2);
  assign vld_p1        = (occ_p1 != 2'd0);
  assign push          = in_valid && in_ready && !flush;
  assign pop           = vld_p1 && out_ready && !flush;
  assign out_valid     = vld_p1;
  assign decoded_count = count_p1;

  // Occupancy, pointers and consumed-entry counter; flush empties, rst wins
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_p1    <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      count_p1  <= '0;
    end else if (flush) begin
      occ_p1    <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
    end else begin
      if (push) wr_ptr_p1 <= ~wr_ptr_p1;
      if (pop) begin
        rd_ptr_p1 <= ~rd_ptr_p1;
        count_p1  <= count_p1 + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_p1 <= occ_p1 + 2'd1;
        2'b01:   occ_p1 <= occ_p1 - 2'd1;
        default: occ_p1 <= occ_p1;
      endcase
    end
  end

  // Entry storage; contents are only visible through the valid-gated outputs
  always_ff @(posedge clk) begin
    if (push) begin
      dec_p1[wr_ptr_p1] <= dec_p0;
      pc_p1[wr_ptr_p1]  <= in_pc;
    end
  end

  assign head  = dec_p1[rd_ptr_p1];
  assign imm_s = head.imm;

  // Present the head entry, forcing every data field to zero while empty
  always_comb begin
    out_pc         = '0;
    out_rd         = '0;
    out_rs1        = '0;
    out_rs2        = '0;
    out_imm        = '0;
    out_alu_op     = '0;
    out_jmp_op     = '0;
    out_mem_op     = '0;
    out_csr_op     = '0;
    out_machine_op = '0;
    out_cust_op    = 1'b0;
    out_mul_op     = '0;
    out_illegal    = 1'b0;
    out_cause      = '0;
    if (vld_p1) begin
      out_pc         = pc_p1[rd_ptr_p1];
      out_rd         = head.rd;
      out_rs1        = head.rs1;
      out_rs2        = head.rs2;
      out_imm        = XLEN'(imm_s);
      out_alu_op     = head.alu_op;
      out_jmp_op     = head.jmp_op;
      out_mem_op     = head.mem_op;
      out_csr_op     = head.csr_op;
      out_machine_op = head.machine_op;
      out_cust_op    = head.cust_op;
      out_mul_op     = head.mul_op;
      out_illegal    = head.illegal;
      out_cause      = head.illegal ? ILLEGAL_CAUSE : 32'd0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps followed by random
// traffic, checked every cycle against a mask/match instruction table and a
// transaction-level FIFO model.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   out_pc, out_imm;
  logic [4:0]        out_rd, out_rs1, out_rs2;
  logic [18:0]       out_alu_op;
  logic [8:0]        out_jmp_op, out_mem_op;
  logic [5:0]        out_csr_op;
  logic [7:0]        out_machine_op, out_mul_op;
  logic              out_cust_op, out_illegal;
  logic [31:0]       out_cause;
  logic [CNT_W-1:0]  decoded_count;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .ILLEGAL_CAUSE(32'd2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_jmp_op(out_jmp_op), .out_mem_op(out_mem_op),
    .out_csr_op(out_csr_op), .out_machine_op(out_machine_op),
    .out_cust_op(out_cust_op), .out_mul_op(out_mul_op),
    .out_illegal(out_illegal), .out_cause(out_cause),
    .decoded_count(decoded_count)
  );

  // Expected decode of one word
  typedef struct packed {
    logic [18:0] alu;
    logic [8:0]  jmp;
    logic [8:0]  mem;
    logic [5:0]  csr;
    logic [7:0]  mach;
    logic        cust;
    logic [7:0]  mul;
    logic        illegal;
    logic [31:0] imm;
  } exp_t;

  // ISA pattern table: grp 0 alu,1 jmp,2 mem,3 csr,4 mach,5 cust,6 mul;
  // fmt 0 none,1 I,2 S,3 B,4 U,5 J
  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [2:0]  grp;
    logic [4:0]  idx;
    logic [2:0]  fmt;
  } pat_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;

  pat_t        pats[$];
  txn_t        mq[$];
  logic [31:0] mcount;
  int          checks   = 0;
  int          failures = 0;

  localparam logic [31:0] M_OP = 32'h0000_007F;
  localparam logic [31:0] M_F3 = 32'h0000_707F;
  localparam logic [31:0] M_F7 = 32'hFE00_707F;
  localparam logic [31:0] M_EX = 32'hFFFF_FFFF;

  function automatic void addp(logic [31:0] mask, logic [31:0] match,
                               int grp, int idx, int fmt);
    pat_t p;
    p.mask = mask; p.match = match;
    p.grp = 3'(grp); p.idx = 5'(idx); p.fmt = 3'(fmt);
    pats.push_back(p);
  endfunction

  function automatic void build_table();
    addp(M_OP, 32'h37, 2, 0, 4);          // lui
    addp(M_OP, 32'h17, 1, 8, 4);          // auipc
    addp(M_OP, 32'h6F, 1, 0, 5);          // jal
    addp(M_F3, 32'h67, 1, 1, 1);          // jalr
    addp(M_F3, 32'h0063, 1, 2, 3);        // beq
    addp(M_F3, 32'h1063, 1, 3, 3);        // bne
    addp(M_F3, 32'h4063, 1, 4, 3);        // blt
    addp(M_F3, 32'h5063, 1, 5, 3);        // bge
    addp(M_F3, 32'h6063, 1, 6, 3);        // bltu
    addp(M_F3, 32'h7063, 1, 7, 3);        // bgeu
    addp(M_F3, 32'h0003, 2, 1, 1);        // lb
    addp(M_F3, 32'h1003, 2, 2, 1);        // lh
    addp(M_F3, 32'h2003, 2, 3, 1);        // lw
    addp(M_F3, 32'h4003, 2, 4, 1);        // lbu
    addp(M_F3, 32'h5003, 2, 5, 1);        // lhu
    addp(M_F3, 32'h0023, 2, 6, 2);        // sb
    addp(M_F3, 32'h1023, 2, 7, 2);        // sh
    addp(M_F3, 32'h2023, 2, 8, 2);        // sw
    addp(M_F3, 32'h0013, 0, 0, 1);        // addi
    addp(M_F3, 32'h2013, 0, 1, 1);        // slti
    addp(M_F3, 32'h3013, 0, 2, 1);        // sltiu
    addp(M_F3, 32'h4013, 0, 3, 1);        // xori
    addp(M_F3, 32'h6013, 0, 4, 1);        // ori
    addp(M_F3, 32'h7013, 0, 5, 1);        // andi
    addp(M_F7, 32'h1013, 0, 6, 1);        // slli
    addp(M_F7, 32'h5013, 0, 7, 1);        // srli
    addp(M_F7, 32'h4000_5013, 0, 8, 1);   // srai
    addp(M_F7, 32'h0033, 0, 9, 0);        // add
    addp(M_F7, 32'h4000_0033, 0, 10, 0);  // sub
    addp(M_F7, 32'h1033, 0, 11, 0);       // sll
    addp(M_F7, 32'h2033, 0, 12, 0);       // slt
    addp(M_F7, 32'h3033, 0, 13, 0);       // sltu
    addp(M_F7, 32'h4033, 0, 14, 0);       // xor
    addp(M_F7, 32'h5033, 0, 15, 0);       // srl
    addp(M_F7, 32'h4000_5033, 0, 16, 0);  // sra
    addp(M_F7, 32'h6033, 0, 17, 0);       // or
    addp(M_F7, 32'h7033, 0, 18, 0);       // and
    addp(M_F3, 32'h1073, 3, 0, 1);        // csrrw
    addp(M_F3, 32'h2073, 3, 1, 1);        // csrrs
    addp(M_F3, 32'h3073, 3, 2, 1);        // csrrc
    addp(M_F3, 32'h5073, 3, 3, 1);        // csrrwi
    addp(M_F3, 32'h6073, 3, 4, 1);        // csrrsi
    addp(M_F3, 32'h7073, 3, 5, 1);        // csrrci
    addp(M_EX, 32'h0010_0073, 4, 0, 0);   // ebreak
    addp(M_EX, 32'h0000_0073, 4, 1, 0);   // ecall
    addp(M_OP, 32'h1F, 5, 0, 0);          // custom
`ifdef DECODE_STAGE_MEXT_EN
    for (int f = 0; f < 8; f++)
      addp(M_F7, 32'h0200_0033 | (32'(f) << 12), 6, f, 0);
`endif
  endfunction

  function automatic exp_t ref_decode(logic [31:0] w);
    exp_t e;
    int   hit;
    e   = '0;
    hit = -1;
    foreach (pats[i]) if ((w & pats[i].mask) == pats[i].match) hit = i;
    if (hit < 0) begin
      e.illegal = 1'b1;
      return e;
    end
    case (pats[hit].grp)
      3'd0:    e.alu[pats[hit].idx]  = 1'b1;
      3'd1:    e.jmp[pats[hit].idx]  = 1'b1;
      3'd2:    e.mem[pats[hit].idx]  = 1'b1;
      3'd3:    e.csr[pats[hit].idx]  = 1'b1;
      3'd4:    e.mach[pats[hit].idx] = 1'b1;
      3'd5:    e.cust                = 1'b1;
      default: e.mul[pats[hit].idx]  = 1'b1;
    endcase
    case (pats[hit].fmt)
      3'd1:    e.imm = 32'($signed(w[31:20]));
      3'd2:    e.imm = 32'($signed({w[31:25], w[11:7]}));
      3'd3:    e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      3'd4:    e.imm = {w[31:12], 12'h000};
      3'd5:    e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs with the model state
  task automatic compare();
    exp_t e;
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("decoded_count", 64'(decoded_count), 64'(mcount));
    if (mq.size() > 0) begin
      e = ref_decode(mq[0].instr);
      chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
      chk("out_regs", 64'({out_rd, out_rs1, out_rs2}),
          64'({mq[0].instr[11:7], mq[0].instr[19:15], mq[0].instr[24:20]}));
      chk("out_ops", 64'({out_alu_op, out_jmp_op, out_mem_op, out_csr_op,
                          out_machine_op, out_cust_op, out_mul_op}),
          64'({e.alu, e.jmp, e.mem, e.csr, e.mach, e.cust, e.mul}));
      chk("out_illegal", 64'(out_illegal), 64'(e.illegal));
      chk("out_cause", 64'(out_cause), e.illegal ? 64'd2 : 64'd0);
      if (!e.illegal) chk("out_imm", 64'(out_imm), 64'(e.imm));
    end else begin
      chk("idle_data0", 64'({out_pc, out_imm}), 64'd0);
      chk("idle_data1", 64'({out_rd, out_rs1, out_rs2, out_alu_op, out_jmp_op,
                             out_mem_op, out_cust_op, out_illegal}), 64'd0);
      chk("idle_data2", 64'({out_csr_op, out_machine_op, out_mul_op, out_cause}), 64'd0);
    end
  endtask

  // Advance one clock, update the model from the pre-edge inputs, then check
  task automatic tick();
    bit   psh, pp;
    txn_t t;
    psh = !rst && !flush && in_valid && (mq.size() < 2);
    pp  = !rst && !flush && out_ready && (mq.size() > 0);
    t.pc    = in_pc;
    t.instr = in_instr;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      mcount = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        mcount++;
      end
      if (psh) mq.push_back(t);
    end
    compare();
  endtask

  // Present one instruction until it is accepted (bounded)
  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    for (int n = 0; n < 20 && !done; n++) begin
      done = (mq.size() < 2) && !flush && !rst;
      tick();
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted instr=0x%0h", w);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [31:0] w;
    pat_t        p;
    k = $urandom_range(0, 9);
    if (k < 2) return $urandom;
    p = pats[$urandom_range(0, pats.size() - 1)];
    w = ($urandom & ~p.mask) | p.match;
    if (k == 2) w[$urandom_range(12, 31)] ^= 1'b1;
    return w;
  endfunction

  logic [31:0] saved_count;

  initial begin
    build_table();
    mcount    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // addi x1,x0,5 with execute ready
    out_ready = 1'b1;
    send(32'h0050_0093, 32'h0000_0100);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_rd", 64'(out_rd), 64'd1);
    chk("addi_alu", 64'(out_alu_op), 64'h1);
    chk("addi_imm", 64'(out_imm), 64'd5);
    tick();
    chk("addi_count", 64'(decoded_count), 64'd1);

    // Backpressure: two accepts fill the buffer, third waits
    out_ready = 1'b0;
    send(32'h0000_0033, 32'h0000_0200);
    send(32'h4020_80B3, 32'h0000_0204);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = 32'h0030_A113;
    in_pc    = 32'h0000_0208;
    tick();
    tick();
    out_ready = 1'b1;
    send(32'h0030_A113, 32'h0000_0208);
    repeat (3) tick();

    // Illegal words
    send(32'h0000_0000, 32'h0000_0300);
    chk("ill0_cause", 64'(out_cause), 64'd2);
    send(32'hFE00_1013, 32'h0000_0304);
    send(32'h0000_2067, 32'h0000_0308);
    send(32'h0020_0073, 32'h0000_030C);
    repeat (2) tick();

    // Store and branch immediates, held at the head
    out_ready = 1'b0;
    send(32'h0011_2223, 32'h0000_0400);
    chk("sw_mem", 64'(out_mem_op), 64'h100);
    chk("sw_imm", 64'(out_imm), 64'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(32'hFE00_0EE3, 32'h0000_0404);
    chk("beq_jmp", 64'(out_jmp_op), 64'h4);
    chk("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
    out_ready = 1'b1;
    tick();

    // Flush a full buffer with a same-cycle push and pop request
    out_ready = 1'b0;
    send(32'h0010_0073, 32'h0000_0500);
    send(32'h0000_0073, 32'h0000_0504);
    saved_count = decoded_count;
    in_valid  = 1'b1;
    in_instr  = 32'h0000_1073;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_count", 64'(decoded_count), 64'(saved_count));
    tick();

    // mul x0,x1,x2
    out_ready = 1'b0;
    send(32'h0220_8033, 32'h0000_0600);
`ifdef DECODE_STAGE_MEXT_EN
    chk("mul_op", 64'(out_mul_op), 64'h1);
`else
    chk("mul_illegal", 64'(out_illegal), 64'd1);
`endif
    out_ready = 1'b1;
    tick();

    // Reset while the buffer holds entries
    out_ready = 1'b0;
    send(32'h1234_50B7, 32'h0000_0700);
    send(32'h0000_006F, 32'h0000_0704);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 150) == 0);
      tick();
    end
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
